// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: memory-side responder for the core's fetch port (read-only)
// and data port (read/write with byte mask). It arbitrates between the two
// ports and serialises each 128-bit line into four 32-bit SRAM beats.
// Optional build macro: LINE_MEM_CTRL_RR_EN selects round-robin arbitration
// on ties; without it the data port always wins a tie.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no transfer; arbitrate and latch the winning request
// S_RD_ISSUE | issue read beats 0..3, capture returning words
// S_RD_DRAIN | capture final read word, load owner's data output
// S_WR_ISSUE | issue write beats 0..3 with per-beat byte enables
// S_DONE     | one-cycle done pulse for the owner port
module line_mem_ctrl #(
  parameter int SRAM_AW = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               rom_read_i,
  input  logic [31:0]        rom_addr_i,
  output logic [127:0]       rom_data_o,
  output logic               busy1,
  output logic               done1,
  input  logic               ram_read_i,
  input  logic               ram_write_i,
  input  logic [31:0]        ram_addr_i,
  input  logic [127:0]       ram_data_i,
  input  logic [15:0]        ram_mask_i,
  output logic [127:0]       ram_data_o,
  output logic               busy2,
  output logic               done2,
  output logic               sram_en,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [3:0]         sram_be,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_DRAIN,
    S_WR_ISSUE,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_own_data;
  logic [SRAM_AW-3:0]   r_line_addr;
  logic [127:0]         r_wdata;
  logic [15:0]          r_mask;
  logic [1:0]           r_beat;
  logic                 r_rd_pend;
  logic [127:0]         r_rd_line;
  logic [127:0]         r_rom_data;
  logic [127:0]         r_ram_data;

  logic                 w_req_rom;
  logic                 w_req_ram;
  logic                 w_grant_data;
  logic                 w_accept;
  logic                 w_issue;
  logic                 w_wr_beat;
  logic [127:0]         w_line_shift;
  logic                 w_unused;

  assign w_req_rom = rom_read_i;
  assign w_req_ram = ram_read_i | ram_write_i;

`ifdef LINE_MEM_CTRL_RR_EN
  logic r_prio_fetch;

  assign w_grant_data = w_req_ram & (~w_req_rom | ~r_prio_fetch);

  // Tie-break pointer: after a data-port win the fetch port gets the next tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prio_fetch <= 1'b0;
    end else if (w_accept) begin
      r_prio_fetch <= w_grant_data;
    end
  end
`else
  assign w_grant_data = w_req_ram;
`endif

  assign w_accept     = (r_state == S_IDLE) & (w_req_rom | w_req_ram);
  assign w_issue      = (r_state == S_RD_ISSUE) | (r_state == S_WR_ISSUE);
  assign w_wr_beat    = (r_state == S_WR_ISSUE);
  assign w_line_shift = {sram_rdata, r_rd_line[127:32]};

  // Only the line-address bits are meaningful; the rest wrap or are ignored.
  assign w_unused = &{1'b0, rom_addr_i[31:SRAM_AW+2], rom_addr_i[3:0],
                      ram_addr_i[31:SRAM_AW+2], ram_addr_i[3:0]};

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and SRAM / handshake outputs.
  always_comb begin
    w_next     = r_state;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_be    = 4'h0;
    sram_wdata = 32'h0;
    busy1      = 1'b0;
    busy2      = 1'b0;
    done1      = 1'b0;
    done2      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // A data request with both ops high is handled as a write.
          w_next = (w_grant_data & ram_write_i) ? S_WR_ISSUE : S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: if (r_beat == 2'd3) w_next = S_RD_DRAIN;
      S_RD_DRAIN: w_next = S_DONE;
      S_WR_ISSUE: if (r_beat == 2'd3) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (w_issue) begin
      sram_en   = 1'b1;
      sram_addr = {r_line_addr, r_beat};
    end
    if (w_wr_beat) begin
      sram_we    = 1'b1;
      sram_be    = r_mask[{r_beat, 2'b00} +: 4];
      sram_wdata = r_wdata[{r_beat, 5'b00000} +: 32];
    end
    if (r_state != S_IDLE) begin
      busy1 = ~r_own_data;
      busy2 = r_own_data;
    end
    if (r_state == S_DONE) begin
      done1 = ~r_own_data;
      done2 = r_own_data;
    end
  end

  // Latch the winning request so the ports may change after acceptance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_own_data  <= 1'b0;
      r_line_addr <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
    end else if (w_accept) begin
      r_own_data  <= w_grant_data;
      r_line_addr <= w_grant_data ? ram_addr_i[SRAM_AW+1:4] : rom_addr_i[SRAM_AW+1:4];
      r_wdata     <= ram_data_i;
      r_mask      <= ram_mask_i;
    end
  end

  // Beat counter and read-return shift; a read word arrives the cycle after its beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_beat    <= 2'd0;
      r_rd_pend <= 1'b0;
      r_rd_line <= '0;
    end else begin
      r_beat    <= w_issue ? r_beat + 2'd1 : 2'd0;
      r_rd_pend <= w_issue & ~w_wr_beat;
      if (r_rd_pend) begin
        r_rd_line <= w_line_shift;
      end
    end
  end

  // Owner's line output is loaded on entry to DONE and held until its next read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rom_data <= '0;
      r_ram_data <= '0;
    end else if (r_state == S_RD_DRAIN) begin
      if (r_own_data) begin
        r_ram_data <= w_line_shift;
      end else begin
        r_rom_data <= w_line_shift;
      end
    end
  end

  assign rom_data_o = r_rom_data;
  assign ram_data_o = r_ram_data;

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Self-checking bench for line_mem_ctrl with a behavioural SRAM and a
// scoreboard of expected completions (port order and read data).
module tb_line_mem_ctrl;

  logic         CLK = 1'b0;
  logic         RST;
  logic         rom_read_i;
  logic [31:0]  rom_addr_i;
  logic [127:0] rom_data_o;
  logic         busy1, done1;
  logic         ram_read_i, ram_write_i;
  logic [31:0]  ram_addr_i;
  logic [127:0] ram_data_i;
  logic [15:0]  ram_mask_i;
  logic [127:0] ram_data_o;
  logic         busy2, done2;
  logic         sram_en, sram_we;
  logic [15:0]  sram_addr;
  logic [3:0]   sram_be;
  logic [31:0]  sram_wdata;
  logic [31:0]  sram_rdata;

  line_mem_ctrl #(.SRAM_AW(16)) dut (
    .CLK(CLK), .RST(RST),
    .rom_read_i(rom_read_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
    .busy1(busy1), .done1(done1),
    .ram_read_i(ram_read_i), .ram_write_i(ram_write_i), .ram_addr_i(ram_addr_i),
    .ram_data_i(ram_data_i), .ram_mask_i(ram_mask_i), .ram_data_o(ram_data_o),
    .busy2(busy2), .done2(done2),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_be(sram_be), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural SRAM and the bench's own reference copy of its contents.
  logic [31:0] mem       [0:65535];
  logic [31:0] model_mem [0:65535];

  always @(posedge CLK) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  function automatic logic [15:0] widx(input logic [31:0] addr, input int k);
    logic [1:0] kb;
    kb = 2'(k);
    return {addr[17:4], kb};
  endfunction

  function automatic logic [127:0] model_line(input logic [31:0] addr);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = model_mem[widx(addr, k)];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [127:0] data, input logic [15:0] mask);
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 4; b++)
        if (mask[4*k+b]) model_mem[widx(addr, k)][8*b +: 8] = data[32*k+8*b +: 8];
  endtask

  task automatic preload(input logic [31:0] addr, input logic [127:0] line);
    for (int k = 0; k < 4; k++) begin
      mem[widx(addr, k)]       = line[32*k +: 32];
      model_mem[widx(addr, k)] = line[32*k +: 32];
    end
  endtask

  typedef struct {
    bit           port_data;
    bit           is_read;
    logic [127:0] data;
  } exp_t;

  exp_t         cq[$];
  exp_t         mon_e;
  logic [127:0] last_rom, last_ram;

  // Completion monitor: every done pulse must match the next expected completion.
  always @(negedge CLK) begin
    if (done1 || done2) begin
      if (cq.size() == 0) begin
        chk("unexpected_done", {done1, done2}, 2'b00);
      end else begin
        mon_e = cq.pop_front();
        chk("done_port", {done1, done2}, mon_e.port_data ? 2'b01 : 2'b10);
        if (mon_e.is_read) begin
          if (mon_e.port_data) chk("ram_data_o", ram_data_o, mon_e.data);
          else                 chk("rom_data_o", rom_data_o, mon_e.data);
        end
      end
    end
  end

  // One complete transaction with per-cycle handshake and SRAM beat checks.
  // Called and returns at a falling edge.
  task automatic run_txn(input bit pd, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [127:0] data, input logic [15:0] mask);
    bit         is_wr;
    int         n_done;
    logic [3:0] exp_st;
    logic [1:0] kb;
    exp_t       x;
    is_wr  = pd && wr;
    n_done = is_wr ? 5 : 6;
    x.port_data = pd;
    x.is_read   = !is_wr;
    x.data      = '0;
    if (is_wr) model_write(addr, data, mask);
    else begin
      x.data = model_line(addr);
      if (pd) last_ram = x.data; else last_rom = x.data;
    end
    cq.push_back(x);
    if (pd) begin
      ram_read_i = rd; ram_write_i = wr; ram_addr_i = addr; ram_data_i = data; ram_mask_i = mask;
    end else begin
      rom_read_i = 1'b1; rom_addr_i = addr;
    end
    for (int c = 1; c <= n_done + 1; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (c <= n_done) exp_st = pd ? {2'b00, 1'b1, c == n_done} : {1'b1, c == n_done, 2'b00};
      else             exp_st = 4'b0000;
      chk("status", {busy1, done1, busy2, done2}, exp_st);
      if (c <= 4) begin
        kb = 2'(c - 1);
        if (is_wr)
          chk("wr_beat", {sram_en, sram_we, sram_addr, sram_be, sram_wdata},
              {2'b11, addr[17:4], kb, mask[4*(c-1) +: 4], data[32*(c-1) +: 32]});
        else
          chk("rd_beat", {sram_en, sram_we, sram_addr}, {2'b10, addr[17:4], kb});
      end else begin
        chk("sram_idle", {sram_en, sram_we}, 2'b00);
      end
      if (c == 1) begin
        rom_addr_i = ~addr; ram_addr_i = ~addr; ram_data_i = ~data; ram_mask_i = ~mask;
      end
      if (c == n_done) begin
        rom_read_i = 1'b0; ram_read_i = 1'b0; ram_write_i = 1'b0;
      end
    end
    chk("rom_hold", rom_data_o, last_rom);
    chk("ram_hold", ram_data_o, last_ram);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] FETCH_LINE = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L20_INIT   = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] WRAP_LINE  = 128'h0BADF00D_12345678_9ABCDEF0_55AA55AA;

  initial begin
    exp_t x;
    logic [3:0] exp_st;
    int n_d1, n_d2;
    bit reraise, finished;
    RST = 1'b1;
    rom_read_i = 0; rom_addr_i = 0;
    ram_read_i = 0; ram_write_i = 0; ram_addr_i = 0; ram_data_i = 0; ram_mask_i = 0;
    sram_rdata = 0;
    last_rom = '0; last_ram = '0;
    for (int i = 0; i < 65536; i++) begin mem[i] = 32'h0; model_mem[i] = 32'h0; end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_status", {busy1, done1, busy2, done2, sram_en, sram_we}, 6'b0);
    chk("rst_rom_data", rom_data_o, '0);
    chk("rst_ram_data", ram_data_o, '0);
    chk("rst_sram_cmd", {sram_addr, sram_be, sram_wdata}, '0);
    RST = 1'b0;
    @(negedge CLK);

    // Fetch read of line 0x100 (words 0x40..0x43).
    preload(32'h100, FETCH_LINE);
    run_txn(1'b0, 1'b1, 1'b0, 32'h100, '0, 16'h0);
    chk("fetch_line", rom_data_o, FETCH_LINE);

    // Masked write: only word 1 enabled, then read back.
    preload(32'h20, L20_INIT);
    run_txn(1'b1, 1'b0, 1'b1, 32'h20, 128'hCAFEF00D_CAFEF00D_DEADBEEF_CAFEF00D, 16'h00F0);
    run_txn(1'b1, 1'b1, 1'b0, 32'h20, '0, 16'h0);
    chk("masked_readback", ram_data_o, 128'hA3A3A3A3_A2A2A2A2_DEADBEEF_A0A0A0A0);

    // Read and write together on the data port behave as a write.
    run_txn(1'b1, 1'b1, 1'b1, 32'h30, 128'h01020304_05060708_090A0B0C_0D0E0F10, 16'hFFFF);
    run_txn(1'b0, 1'b1, 1'b0, 32'h30, '0, 16'h0);

    // Address wrap: 0x40000 and 0x0 name the same line.
    run_txn(1'b1, 1'b0, 1'b1, 32'h40000, WRAP_LINE, 16'hFFFF);
    run_txn(1'b1, 1'b1, 1'b0, 32'h0, '0, 16'h0);
    chk("wrap_readback", ram_data_o, WRAP_LINE);

    // Reset in cycle 3 of a fetch read.
    rom_read_i = 1'b1; rom_addr_i = 32'h100;
    for (int c = 1; c <= 3; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("abort_status", {busy1, done1, busy2, done2}, 4'b1000);
    end
    RST = 1'b1; rom_read_i = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_rst_status", {busy1, done1, busy2, done2, sram_en, sram_we}, 6'b0);
    chk("abort_rst_rom", rom_data_o, '0);
    chk("abort_rst_ram", ram_data_o, '0);
    RST = 1'b0;
    last_rom = '0; last_ram = '0;
    @(negedge CLK);
    run_txn(1'b0, 1'b1, 1'b0, 32'h100, '0, 16'h0);

    // Tie with the data winner not re-requesting: fetch follows right after DONE.
    model_write(32'h50, 128'h50505050_51515151_52525252_53535353, 16'hFFFF);
    x.port_data = 1'b1; x.is_read = 1'b0; x.data = '0; cq.push_back(x);
    x.port_data = 1'b0; x.is_read = 1'b1; x.data = model_line(32'h100); cq.push_back(x);
    last_rom = x.data;
    rom_read_i = 1'b1; rom_addr_i = 32'h100;
    ram_write_i = 1'b1; ram_addr_i = 32'h50; ram_mask_i = 16'hFFFF;
    ram_data_i = 128'h50505050_51515151_52525252_53535353;
    for (int c = 1; c <= 13; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (c <= 5)       exp_st = {2'b00, 1'b1, c == 5};
      else if (c == 6)  exp_st = 4'b0000;
      else if (c <= 12) exp_st = {1'b1, c == 12, 2'b00};
      else              exp_st = 4'b0000;
      chk("tie1_status", {busy1, done1, busy2, done2}, exp_st);
      if (c == 5)  ram_write_i = 1'b0;
      if (c == 12) rom_read_i = 1'b0;
    end

    // Two consecutive tie rounds: the data port re-requests right after its DONE.
    x.is_read = 1'b0; x.data = '0; x.port_data = 1'b1; cq.push_back(x);
    model_write(32'h60, 128'h66666666_66666666_66666666_66666666, 16'hFFFF);
`ifdef LINE_MEM_CTRL_RR_EN
    x.port_data = 1'b0; x.is_read = 1'b1; x.data = model_line(32'h100); cq.push_back(x);
    x.port_data = 1'b1; x.is_read = 1'b0; x.data = '0; cq.push_back(x);
`else
    x.port_data = 1'b1; x.is_read = 1'b0; x.data = '0; cq.push_back(x);
    x.port_data = 1'b0; x.is_read = 1'b1; x.data = model_line(32'h100); cq.push_back(x);
`endif
    model_write(32'h70, 128'h77777777_77777777_77777777_77777777, 16'hFFFF);
    rom_read_i = 1'b1; rom_addr_i = 32'h100;
    ram_write_i = 1'b1; ram_addr_i = 32'h60; ram_mask_i = 16'hFFFF;
    ram_data_i = 128'h66666666_66666666_66666666_66666666;
    n_d1 = 0; n_d2 = 0; reraise = 1'b0; finished = 1'b0;
    for (int c = 0; c < 80 && !finished; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (reraise) begin
        ram_write_i = 1'b1; ram_addr_i = 32'h70; ram_mask_i = 16'hFFFF;
        ram_data_i = 128'h77777777_77777777_77777777_77777777;
        reraise = 1'b0;
      end
      if (done1) begin rom_read_i = 1'b0; n_d1++; end
      if (done2) begin
        ram_write_i = 1'b0;
        if (n_d2 == 0) reraise = 1'b1;
        n_d2++;
      end
      if (n_d1 == 1 && n_d2 == 2) finished = 1'b1;
    end
    chk("tie2_completed", {31'b0, finished}, 32'd1);
    rom_read_i = 1'b0; ram_write_i = 1'b0;
    @(negedge CLK);

    // Confirm the second-round write landed.
    run_txn(1'b1, 1'b1, 1'b0, 32'h70, '0, 16'h0);
    chk("tie2_write_readback", ram_data_o, 128'h77777777_77777777_77777777_77777777);

    chk("scoreboard_empty", cq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
